regfile_bypass_n: RTL and testbench
===================================

Name: regfile_bypass_n

Overview:
- Parametrised successor to the ID-stage register file.
- Provides NUM_RD combinational read ports with per-byte forwarding from NUM_FWD in-flight pipeline stages and the WB write port.
- Writes carry byte strobes, for partial-word loads such as LWL/LWR and SB/SH-style merges.
- Detects load-use hazards against stages whose result is not yet available and raises a stall to ID.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_FWD, 3, number of forwarding stages. Index 0 is youngest (EX), index NUM_FWD-1 is oldest.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  Clock; all state updates on its rising edge.
- resetn  in  1  Asynchronous reset, active-low.
- rd_en  in  NUM_RD  Per-port read enable; gates stall contribution only.
- raddr  in  NUM_RD*ADDR_W  Read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  Read data, packed the same way.
- fwd_we  in  NUM_FWD  Stage k writes a register.
- fwd_waddr  in  NUM_FWD*ADDR_W  Destination register of stage k.
- fwd_wstrb  in  NUM_FWD*DATA_W/8  Byte strobes of stage k.
- fwd_wdata  in  NUM_FWD*DATA_W  Result of stage k.
- fwd_pend  in  NUM_FWD  Stage k result not yet available (load in flight).
- we  in  1  Architectural write enable (WB).
- waddr  in  ADDR_W  Write address.
- wstrb  in  DATA_W/8  Write byte strobes.
- wdata  in  DATA_W  Write data.
- stall  out  1  Load-use hazard; ID must hold.
- stall_cnt  out  CNT_W  Saturating count of cycles with stall=1.

Behaviour:
- Storage: 2**ADDR_W x DATA_W array.
- Reset: resetn low immediately and asynchronously clears every entry and stall_cnt to 0. This holds even mid-write; a write in the same cycle as reset is lost.
- Write:
  - On the rising edge with we=1 and waddr!=0, byte b of entry waddr takes wdata byte b where wstrb[b]=1. Other bytes are kept.
  - wstrb=0 means no change.
  - Entry 0 is never written and reads as 0.
- Read:
  - Fully combinational, zero latency.
  - Resolution is per byte b of port i. When raddr_i=0 the result is 0. Otherwise the byte comes from the youngest source, in order stage 0..NUM_FWD-1 then the WB port, that has a write enable set, an address equal to raddr_i, and strobe bit b set.
  - If no source matches, the byte comes from the array. Different bytes may come from different sources.
  - The WB port bypasses the array in the same cycle, giving write-before-read semantics.
- Stall:
  - Stall is combinational: stall=1 iff some port i has rd_en_i=1 and raddr_i!=0, and some stage k has fwd_we_k=1, fwd_pend_k=1, fwd_waddr_k=raddr_i and fwd_wstrb_k!=0.
  - A pending stage triggers stall even if a younger stage covers all bytes. This is conservative and a decided rule.
  - The WB port never causes a stall.
  - While stall=1, rdata is still computed by the normal rules, using fwd_wdata of pending stages as-is; ID discards it.
- stall_cnt:
  - Increments by 1 on each rising edge where stall=1.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Cleared only by reset.
- Simultaneous events: two stages targeting the same register are resolved per byte by age. A forwarding stage and the WB port targeting the same register give the forwarding stage priority.
- No X propagation: unused strobe bits of disabled sources are ignored.

Decomposition:
- Shared package contents:
  - Constant for byte lanes (DATA_W/8).
  - Zero-register address constant.
  - Forwarding-bus field offsets, replacing the hand-packed {we,waddr,data} 38-bit buses.
- One sub-module, regfile_byte_sel: resolves one byte lane for one read port from the priority-ordered sources. Instantiate it NUM_RD x DATA_W/8 times in a generate loop.

Test Plan:
- Reset and read-back:
  - Assert resetn=0 mid-write, release, read all 32 registers -> all 0, stall_cnt=0.
  - Write r5=0x12345678 with wstrb=0xF, read next cycle -> 0x12345678.
- Byte strobes: r5=0x12345678, write wdata=0xAABBCCDD with wstrb=0x5 -> r5 reads 0x12BB56DD.
- Forwarding priority:
  - Array r7=0x11111111. Stage2 writes r7 0x22222222 with strobe 0xF; stage0 writes r7 0x33333333 with strobe 0x3.
  - Expected: rdata=0x22223333 on both ports.
- r0 immunity: we=1, waddr=0, wdata=0xFFFFFFFF, plus stage0 forwarding to r0 -> rdata for raddr=0 is 0; array entry unchanged.
- Load-use stall:
  - Stage0 fwd_pend=1 targeting r9, port1 raddr=9 with rd_en=1 -> stall=1. Hold 3 cycles, then drop pend -> stall=0 and stall_cnt=3.
  - With rd_en=0 -> stall=0.
- Counter saturation: with CNT_W=4, hold stall for 20 cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/regfile_bypass_n_pkg.sv
// Shared constants and forwarding-bus field helpers for the bypassing register file.
// Bus offsets are computed here instead of hand-packing fixed-width {we,waddr,data} words.
package regfile_bypass_n_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ZERO_REG = 0;

  function automatic int unsigned byte_lanes(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

  function automatic int unsigned fwd_addr_lsb(input int unsigned k, input int unsigned aw);
    return k * aw;
  endfunction

  function automatic int unsigned fwd_strb_lsb(input int unsigned k, input int unsigned nb);
    return k * nb;
  endfunction

  function automatic int unsigned fwd_data_lsb(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/regfile_byte_sel.sv
// Resolves one byte lane of one read port: the lowest-index hitting source wins,
// otherwise the array byte; the zero register always reads 0.
module regfile_byte_sel
  import regfile_bypass_n_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0]        i_hit,
  input  logic [NSRC*BYTE_W-1:0] i_src,
  input  logic [BYTE_W-1:0]      i_arr,
  input  logic                   i_zero,
  output logic [BYTE_W-1:0]      o_byte
);

  logic w_found;

  always_comb begin
    o_byte  = i_arr;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!w_found && i_hit[k]) begin
        o_byte  = i_src[k*BYTE_W +: BYTE_W];
        w_found = 1'b1;
      end
    end
    if (i_zero) o_byte = '0;
  end

endmodule

// File: rtl/regfile_bypass_n.sv
// ID-stage register file with byte-strobed writes, per-byte forwarding from
// NUM_FWD pipeline stages plus WB, load-use stall detection and a stall counter.
module regfile_bypass_n
  import regfile_bypass_n_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]       raddr,
  output logic [NUM_RD*DATA_W-1:0]       rdata,
  input  logic [NUM_FWD-1:0]             fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0]      fwd_waddr,
  input  logic [NUM_FWD*(DATA_W/8)-1:0]  fwd_wstrb,
  input  logic [NUM_FWD*DATA_W-1:0]      fwd_wdata,
  input  logic [NUM_FWD-1:0]             fwd_pend,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W/8-1:0]            wstrb,
  input  logic [DATA_W-1:0]              wdata,
  output logic                           stall,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int unsigned NB    = byte_lanes(DATA_W);
  localparam int unsigned NSRC  = NUM_FWD + 1;
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else if (we && (waddr != ADDR_W'(ZERO_REG))) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb[b]) r_mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Source order per lane: stages 0..NUM_FWD-1 (youngest first), then WB last.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_rzero;
    logic [DATA_W-1:0] w_arr;

    assign w_raddr = raddr[i*ADDR_W +: ADDR_W];
    assign w_rzero = (w_raddr == ADDR_W'(ZERO_REG));
    assign w_arr   = r_mem[w_raddr];

    for (genvar b = 0; b < NB; b++) begin : g_byte
      logic [NSRC-1:0]        w_hit;
      logic [NSRC*BYTE_W-1:0] w_src;

      for (genvar k = 0; k < NUM_FWD; k++) begin : g_src
        assign w_hit[k] = fwd_we[k]
                       && (fwd_waddr[fwd_addr_lsb(k, ADDR_W) +: ADDR_W] == w_raddr)
                       && fwd_wstrb[fwd_strb_lsb(k, NB) + b];
        assign w_src[k*BYTE_W +: BYTE_W] =
          fwd_wdata[fwd_data_lsb(k, DATA_W) + b*BYTE_W +: BYTE_W];
      end

      assign w_hit[NUM_FWD] = we && (waddr == w_raddr) && wstrb[b];
      assign w_src[NUM_FWD*BYTE_W +: BYTE_W] = wdata[b*BYTE_W +: BYTE_W];

      regfile_byte_sel #(.NSRC(NSRC)) u_sel (
        .i_hit  (w_hit),
        .i_src  (w_src),
        .i_arr  (w_arr[b*BYTE_W +: BYTE_W]),
        .i_zero (w_rzero),
        .o_byte (rdata[i*DATA_W + b*BYTE_W +: BYTE_W])
      );
    end
  end

  // Any pending stage hit stalls, even when a younger stage already covers the word.
  always_comb begin
    w_stall = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (rd_en[i] && (raddr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
            && fwd_we[k] && fwd_pend[k]
            && (fwd_waddr[fwd_addr_lsb(k, ADDR_W) +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])
            && (|fwd_wstrb[fwd_strb_lsb(k, NB) +: NB])) begin
          w_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_regfile_bypass_n.sv
// Directed bench for regfile_bypass_n: table of combinational read/stall vectors
// plus hand sequences for reset, strobed writes, stall counting and saturation.
module tb_regfile_bypass_n;

  logic         clk;
  logic         resetn;
  logic [1:0]   rd_en;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic [2:0]   fwd_we;
  logic [14:0]  fwd_waddr;
  logic [11:0]  fwd_wstrb;
  logic [95:0]  fwd_wdata;
  logic [2:0]   fwd_pend;
  logic         we;
  logic [4:0]   waddr;
  logic [3:0]   wstrb;
  logic [31:0]  wdata;
  logic         stall;
  logic [3:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_bypass_n #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_FWD(3), .CNT_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wstrb(fwd_wstrb),
    .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend), .we(we), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  fwe;
    logic [14:0] fwa;
    logic [11:0] fws;
    logic [95:0] fwd;
    logic [2:0]  fpd;
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic [1:0]  ren;
    logic [9:0]  ra;
    logic [63:0] exp_rd;
    logic        exp_st;
    string       name;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    fwd_we = '0; fwd_waddr = '0; fwd_wstrb = '0; fwd_wdata = '0; fwd_pend = '0;
    we = 1'b0; waddr = '0; wstrb = '0; wdata = '0; rd_en = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wstrb = s; wdata = d;
    @(negedge clk);
    we = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
  endtask

  task automatic set_stall_r9();
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd9}; fwd_wstrb = {4'h0, 4'h0, 4'hF};
    fwd_pend = 3'b001; rd_en = 2'b10; raddr = {5'd9, 5'd0};
  endtask

  initial begin
    vecs[0]  = '{3'b000, 15'd0, 12'h0, 96'h0, 3'b000, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b00, {5'd7, 5'd5}, {32'h11111111, 32'h12BB56DD}, 1'b0, "array_read"};
    vecs[1]  = '{3'b101, {5'd7, 5'd0, 5'd7}, {4'hF, 4'h0, 4'h3},
                 {32'h22222222, 32'h0, 32'h33333333}, 3'b000, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b11, {5'd7, 5'd7}, {32'h22223333, 32'h22223333}, 1'b0, "fwd_prio"};
    vecs[2]  = '{3'b001, 15'd0, {4'h0, 4'h0, 4'hF}, {64'h0, 32'hFFFFFFFF}, 3'b000,
                 1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 2'b11, {5'd0, 5'd0}, 64'h0, 1'b0, "r0_immune"};
    vecs[3]  = '{3'b000, 15'd0, 12'h0, 96'h0, 3'b000, 1'b1, 5'd5, 4'h8, 32'hEE000000,
                 2'b11, {5'd5, 5'd5}, {32'hEEBB56DD, 32'hEEBB56DD}, 1'b0, "wb_bypass"};
    vecs[4]  = '{3'b010, {5'd0, 5'd5, 5'd0}, {4'h0, 4'h9, 4'h0},
                 {32'h0, 32'hA10000A2, 32'h0}, 3'b000, 1'b1, 5'd5, 4'hF, 32'h55555555,
                 2'b00, {5'd5, 5'd9}, {32'hA15555A2, 32'h99999999}, 1'b0, "fwd_over_wb"};
    vecs[5]  = '{3'b001, {5'd0, 5'd0, 5'd9}, {4'h0, 4'h0, 4'hF},
                 {32'h0, 32'h0, 32'h0BADF00D}, 3'b001, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b10, {5'd9, 5'd5}, {32'h0BADF00D, 32'h12BB56DD}, 1'b1, "stall_pend"};
    vecs[6]  = '{3'b001, {5'd0, 5'd0, 5'd9}, {4'h0, 4'h0, 4'hF},
                 {32'h0, 32'h0, 32'h0BADF00D}, 3'b001, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b00, {5'd9, 5'd5}, {32'h0BADF00D, 32'h12BB56DD}, 1'b0, "stall_rden0"};
    vecs[7]  = '{3'b011, {5'd0, 5'd9, 5'd9}, {4'h0, 4'h1, 4'hF},
                 {32'h0, 32'hFFFFFFFF, 32'h01020304}, 3'b010, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b01, {5'd0, 5'd9}, {32'h0, 32'h01020304}, 1'b1, "pend_covered"};
    vecs[8]  = '{3'b001, {5'd0, 5'd0, 5'd9}, 12'h0, {64'h0, 32'hFFFFFFFF}, 3'b001,
                 1'b0, 5'd0, 4'h0, 32'h0, 2'b11, {5'd9, 5'd9},
                 {32'h99999999, 32'h99999999}, 1'b0, "pend_zero_strb"};
    vecs[9]  = '{3'b100, 15'd0, {4'hF, 4'h0, 4'h0}, {32'hFFFFFFFF, 64'h0}, 3'b100,
                 1'b0, 5'd0, 4'h0, 32'h0, 2'b11, {5'd0, 5'd0}, 64'h0, 1'b0, "pend_r0"};
    vecs[10] = '{3'b000, {5'd0, 5'd0, 5'd9}, {4'h0, 4'h0, 4'hF}, {64'h0, 32'hFFFFFFFF},
                 3'b001, 1'b0, 5'd0, 4'h0, 32'h0, 2'b11, {5'd9, 5'd9},
                 {32'h99999999, 32'h99999999}, 1'b0, "pend_no_we"};
    vecs[11] = '{3'b111, {5'd7, 5'd7, 5'd7}, {4'h4, 4'h2, 4'h1},
                 {32'h00CC0000, 32'h0000BB00, 32'h000000AA}, 3'b000, 1'b1, 5'd7, 4'h8,
                 32'hDD000000, 2'b00, {5'd7, 5'd7}, {32'hDDCCBBAA, 32'hDDCCBBAA}, 1'b0, "byte_mix"};
    vecs[12] = '{3'b101, {5'd7, 5'd0, 5'd7}, {4'hF, 4'h0, 4'hC},
                 {32'h56565656, 32'h0, 32'h12340000}, 3'b000, 1'b0, 5'd0, 4'h0, 32'h0,
                 2'b00, {5'd7, 5'd7}, {32'h12345656, 32'h12345656}, 1'b0, "older_byte"};

    idle();
    raddr  = '0;
    resetn = 1'b0;
    #12 resetn = 1'b1;
    #1 chk("reset_cnt", 64'(stall_cnt), 64'h0);

    // Reset in the middle of a write: array clears at once and the write is lost.
    wr(5'd3, 4'hF, 32'hDEADBEEF);
    raddr = {5'd3, 5'd3};
    #1 chk("pre_reset_r3", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wstrb = 4'hF; wdata = 32'hCAFEF00D; resetn = 1'b0;
    #1 chk("async_clear_r3", rdata, 64'h0);
    @(negedge clk);
    we = 1'b0; waddr = '0; wstrb = '0; wdata = '0; resetn = 1'b1;
    raddr = {5'd4, 5'd4};
    #1 chk("reset_write_lost", rdata, 64'h0);
    for (int r = 0; r < 32; r++) begin
      raddr = {5'(31 - r), 5'(r)};
      #1 chk($sformatf("reset_r%0d", r), rdata, 64'h0);
    end
    chk("reset_cnt2", 64'(stall_cnt), 64'h0);

    wr(5'd5, 4'hF, 32'h12345678);
    raddr = {5'd5, 5'd5};
    #1 chk("full_write", rdata, {32'h12345678, 32'h12345678});
    wr(5'd5, 4'h5, 32'hAABBCCDD);
    #1 chk("strobe_write", rdata, {32'h12BB56DD, 32'h12BB56DD});
    wr(5'd5, 4'h0, 32'hFFFFFFFF);
    #1 chk("zero_strobe", rdata, {32'h12BB56DD, 32'h12BB56DD});
    wr(5'd7, 4'hF, 32'h11111111);
    wr(5'd9, 4'hF, 32'h99999999);
    wr(5'd0, 4'hF, 32'hFFFFFFFF);
    raddr = {5'd0, 5'd5};
    #1 chk("r0_write_ignored", rdata, {32'h0, 32'h12BB56DD});

    // Vectors are driven just after a falling edge and removed before the next rising edge.
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      fwd_we = vecs[v].fwe; fwd_waddr = vecs[v].fwa; fwd_wstrb = vecs[v].fws;
      fwd_wdata = vecs[v].fwd; fwd_pend = vecs[v].fpd; we = vecs[v].we;
      waddr = vecs[v].wa; wstrb = vecs[v].ws; wdata = vecs[v].wd;
      rd_en = vecs[v].ren; raddr = vecs[v].ra;
      #1;
      chk({vecs[v].name, "_rdata"}, rdata, vecs[v].exp_rd);
      chk({vecs[v].name, "_stall"}, 64'(stall), 64'(vecs[v].exp_st));
      idle();
    end
    chk("cnt_after_table", 64'(stall_cnt), 64'h0);

    @(negedge clk);
    set_stall_r9();
    #1 chk("stall_on", 64'(stall), 64'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle();
    #1 chk("stall_off", 64'(stall), 64'h0);
    chk("stall_cnt3", 64'(stall_cnt), 64'h3);

    @(negedge clk);
    resetn = 1'b0;
    #1 chk("cnt_async_reset", 64'(stall_cnt), 64'h0);
    resetn = 1'b1;
    set_stall_r9();
    repeat (14) @(posedge clk);
    #1 chk("cnt14", 64'(stall_cnt), 64'hE);
    @(posedge clk);
    #1 chk("cnt15", 64'(stall_cnt), 64'hF);
    repeat (5) @(posedge clk);
    #1 chk("cnt_saturated", 64'(stall_cnt), 64'hF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
